// File: rtl/demux4x32_buf_pkg.sv
// Shared constants and slot state encoding for the 1-to-4 buffered demultiplexer.
package demux4x32_buf_pkg;

   localparam int NPORTS    = 4;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

endpackage : demux4x32_buf_pkg

// File: rtl/demux_slot.sv
// One output port: single-entry word buffer, EMPTY/FULL state and delivered-word counter.
module demux_slot
   import demux4x32_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] count
);

   slot_state_t state;
   logic        pop;

   assign valid = (state == SLOT_FULL);
   assign pop   = valid & ready;

   // Buffer state, word capture and delivery count; a pop and push together keep the slot full.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SLOT_EMPTY;
         data  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            data <= push_data;
         end
         if (pop) begin
            count <= count + CNT_W'(1);
         end
         case (state)
            SLOT_EMPTY: if (push)         state <= SLOT_FULL;
            SLOT_FULL:  if (pop && !push) state <= SLOT_EMPTY;
            default:                      state <= SLOT_EMPTY;
         endcase
      end
   end

endmodule : demux_slot

// File: rtl/demux4x32_buf.sv
// Buffered 1-to-4 demultiplexer: routes each upstream word to the port chosen by in_sel.
module demux4x32_buf
   import demux4x32_buf_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [1:0]                in_sel,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [NPORTS*WIDTH-1:0]   out_data,
   output logic [NPORTS-1:0]         out_valid,
   input  logic [NPORTS-1:0]         out_ready,
   output logic [NPORTS*CNT_W-1:0]   out_count
);

   logic [NPORTS-1:0] push;

   // Only the addressed port can stall upstream; it accepts when empty or draining this cycle.
   assign in_ready = !out_valid[in_sel] | out_ready[in_sel];

   // One-hot push decode; in_valid gates away any unknown select or data when idle.
   always_comb begin
      push = '0;
      for (int i = 0; i < NPORTS; i++) begin
         push[i] = in_valid & in_ready & (in_sel == 2'(i));
      end
   end

   for (genvar g = 0; g < NPORTS; g++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .push      (push[g]),
         .push_data (in_data),
         .ready     (out_ready[g]),
         .valid     (out_valid[g]),
         .data      (out_data[g*WIDTH +: WIDTH]),
         .count     (out_count[g*CNT_W +: CNT_W])
      );
   end

endmodule : demux4x32_buf

// File: tb/tb_demux4x32_buf.sv
// Directed and randomized checks of the buffered 1-to-4 demultiplexer against hand values and a queue model.
module tb_demux4x32_buf;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  in_data;
   logic [1:0]   in_sel;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_data;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [31:0]  out_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mq[4][$];
   logic [7:0]  mcnt[4];
   logic        exp_rdy;
   logic [3:0]  mvalid;

   demux4x32_buf dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("reset_valid", out_valid, 4'b0000);
      check("reset_data", out_data, 128'h0);
      check("reset_count", out_count, 32'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check("reset_in_ready", in_ready, 1'b1);
      end

      // First word to port 2
      in_valid = 1'b1;
      in_sel   = 2'd2;
      in_data  = 32'hDEADBEEF;
      tick();
      in_valid = 1'b0;
      #1;
      check("p2_valid", out_valid, 4'b0100);
      check("p2_data", out_data[64 +: 32], 32'hDEADBEEF);
      check("p2_ready_sel2", in_ready, 1'b0);
      in_sel = 2'd0;
      #1;
      check("p2_ready_sel0", in_ready, 1'b1);

      // Fill port 1, then replace its word while it drains
      in_valid = 1'b1;
      in_sel   = 2'd1;
      in_data  = 32'h12345678;
      tick();
      check("p1_fill_valid", out_valid, 4'b0110);
      check("p1_fill_data", out_data[32 +: 32], 32'h12345678);
      out_ready = 4'b0010;
      in_data   = 32'h11111111;
      #1;
      check("p1_replace_ready", in_ready, 1'b1);
      tick();
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      #1;
      check("p1_replace_valid", out_valid, 4'b0110);
      check("p1_replace_data", out_data[32 +: 32], 32'h11111111);
      check("p1_replace_count", out_count, 32'h0000_0100);

      // Port 3 stalled blocks only its own traffic
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 32'h33333333;
      tick();
      in_data = 32'h99999999;
      #1;
      check("p3_blocked_ready", in_ready, 1'b0);
      tick();
      check("p3_blocked_data", out_data[96 +: 32], 32'h33333333);
      in_sel  = 2'd0;
      in_data = 32'hA5A5A5A5;
      #1;
      check("p0_open_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      check("all_full_valid", out_valid, 4'b1111);
      check("p0_data", out_data[0 +: 32], 32'hA5A5A5A5);
      check("p3_held_data", out_data[96 +: 32], 32'h33333333);

      // Reset while full, with push and pops requested in the reset cycle
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_sel    = 2'd1;
      in_data   = 32'h77777777;
      out_ready = 4'b1111;
      tick();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      #1;
      check("rst2_valid", out_valid, 4'b0000);
      check("rst2_data", out_data, 128'h0);
      check("rst2_count", out_count, 32'h0);
      check("rst2_in_ready", in_ready, 1'b1);

      // Port 0 streams 256 pops with a new word every cycle
      in_valid = 1'b1;
      in_sel   = 2'd0;
      in_data  = 32'd0;
      tick();
      out_ready = 4'b0001;
      for (int i = 1; i <= 256; i++) begin
         in_data = 32'(i);
         tick();
         if (i == 255) check("cnt0_255", out_count, 32'h0000_00FF);
      end
      check("cnt0_wrap", out_count, 32'h0);
      check("stream_data", out_data[0 +: 32], 32'd256);
      check("stream_valid", out_valid, 4'b0001);
      in_valid = 1'b0;
      tick();
      check("cnt0_after", out_count, 32'h0000_0001);
      check("drain_valid", out_valid, 4'b0000);

      // Unknown select and data are ignored while idle
      out_ready = 4'b0000;
      in_sel    = 'x;
      in_data   = 'x;
      tick();
      check("x_idle_valid", out_valid, 4'b0000);
      check("x_idle_count", out_count, 32'h0000_0001);

      // Randomized traffic against a per-port queue model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         mcnt[i] = '0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = $urandom;
         out_ready = 4'($urandom_range(0, 15));
         #1;
         for (int i = 0; i < 4; i++) mvalid[i] = (mq[i].size() != 0);
         exp_rdy = !mvalid[in_sel] || out_ready[in_sel];
         check("rnd_in_ready", in_ready, exp_rdy);
         check("rnd_valid", out_valid, mvalid);
         for (int i = 0; i < 4; i++) begin
            if (mvalid[i] && out_ready[i]) begin
               check("rnd_pop_data", out_data[i*32 +: 32], mq[i][0]);
               void'(mq[i].pop_front());
               mcnt[i] = mcnt[i] + 8'd1;
            end
         end
         if (in_valid && exp_rdy) mq[in_sel].push_back(in_data);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      #1;
      for (int i = 0; i < 4; i++) mvalid[i] = (mq[i].size() != 0);
      check("rnd_final_valid", out_valid, mvalid);
      check("rnd_final_count", out_count, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_demux4x32_buf
